// File: rtl/region_guard_pkg.sv
// Shared constants, types and helpers for the AXI region guard.
// Register offsets, bit positions and response codes live here.
package region_guard_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_VCOUNT = 8'h08;
  localparam logic [7:0] OFF_VADDR  = 8'h0C;
  localparam logic [7:0] OFF_RGN0   = 8'h10;

  localparam logic [1:0] FLD_BASE  = 2'd0;
  localparam logic [1:0] FLD_LIMIT = 2'd1;
  localparam logic [1:0] FLD_PERM  = 2'd2;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_DEF = 1;
  localparam int CTRL_IRQ = 2;

  localparam int PERM_R = 0;
  localparam int PERM_W = 1;
  localparam int PERM_V = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [3:0] NO_MATCH = 4'hF;

  typedef enum logic [1:0] {
    CFG_IDLE,
    CFG_WRESP,
    CFG_RDATA
  } cfg_state_t;

  function automatic logic [31:0] apply_strb(
    input logic [31:0] old,
    input logic [31:0] data,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = strb[b] ? data[8*b +: 8] : old[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/region_match.sv
// Region lookup: inclusive base/limit compare with
// lowest-index priority. Purely combinational.
module region_match
  import region_guard_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic [ADDR_WIDTH-1:0]                  addr,
  input  logic                                   write,
  input  logic [NUM_REGIONS-1:0][ADDR_WIDTH-1:0] base,
  input  logic [NUM_REGIONS-1:0][ADDR_WIDTH-1:0] limit,
  input  logic [NUM_REGIONS-1:0][2:0]            perm,
  output logic                                   hit,
  output logic [3:0]                             region,
  output logic                                   perm_ok
);

  // Scan downward so the lowest matching index is the last writer.
  always_comb begin
    hit     = 1'b0;
    region  = NO_MATCH;
    perm_ok = 1'b0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (perm[i][PERM_V] &&
          base[i] <= addr &&
          addr <= limit[i]) begin
        hit     = 1'b1;
        region  = 4'(i);
        perm_ok = write ? perm[i][PERM_W]
                        : perm[i][PERM_R];
      end
    end
  end

endmodule

// File: rtl/axi_region_guard.sv
// AXI4-Lite configured address region guard with a
// single-entry check pipeline and violation tracking.
module axi_region_guard
  import region_guard_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_REGIONS = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [7:0]            S_AXI_AWADDR,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [31:0]           S_AXI_WDATA,
  input  logic [3:0]            S_AXI_WSTRB,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  input  logic [7:0]            S_AXI_ARADDR,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [31:0]           S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY,
  input  logic                  chk_valid,
  output logic                  chk_ready,
  input  logic [ADDR_WIDTH-1:0] chk_addr,
  input  logic                  chk_write,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_allow,
  output logic [3:0]            res_region,
  output logic                  irq
);

  localparam logic [3:0] NR = 4'(NUM_REGIONS);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  cfg_state_t state_q, state_d;
  logic       wr_go, rd_go;

  logic [2:0]           ctrl_q;
  logic                 viol_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [31:0]          vaddr_q;
  logic [1:0]           bresp_q;
  logic [31:0]          rdata_q;

  logic [31:0] base_q  [NUM_REGIONS];
  logic [31:0] limit_q [NUM_REGIONS];
  logic [2:0]  perm_q  [NUM_REGIONS];

  // ---- config FSM ----
  always_comb begin
    state_d = state_q;
    wr_go   = 1'b0;
    rd_go   = 1'b0;
    unique case (state_q)
      CFG_IDLE: begin
        if (S_AXI_AWVALID && S_AXI_WVALID) begin
          wr_go   = 1'b1;
          state_d = CFG_WRESP;
        end else if (S_AXI_ARVALID) begin
          rd_go   = 1'b1;
          state_d = CFG_RDATA;
        end
      end
      CFG_WRESP: if (S_AXI_BREADY) state_d = CFG_IDLE;
      CFG_RDATA: if (S_AXI_RREADY) state_d = CFG_IDLE;
      default:   state_d = CFG_IDLE;
    endcase
    if (ARESET) begin
      wr_go = 1'b0;
      rd_go = 1'b0;
    end
  end

  assign S_AXI_AWREADY = wr_go;
  assign S_AXI_WREADY  = wr_go;
  assign S_AXI_ARREADY = rd_go;
  assign S_AXI_BVALID  = state_q == CFG_WRESP;
  assign S_AXI_RVALID  = state_q == CFG_RDATA;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;

  // ---- write decode ----
  logic [7:0] wa;
  logic [3:0] w_idx;
  logic       w_ctrl, w_stat, w_rgn, w_ok;

  assign wa     = S_AXI_AWADDR;
  assign w_idx  = wa[7:4] - OFF_RGN0[7:4];
  assign w_ctrl = wa == OFF_CTRL;
  assign w_stat = wa == OFF_STATUS;
  assign w_rgn  = wa[1:0] == 2'b00 &&
                  wa[7:4] >= OFF_RGN0[7:4] &&
                  w_idx < NR &&
                  wa[3:2] != 2'd3;
  assign w_ok   = w_ctrl || w_stat || w_rgn;

  // ---- read decode ----
  logic [7:0]  ra;
  logic [3:0]  r_idx;
  logic        r_rgn;
  logic [31:0] rd_mux;

  assign ra    = S_AXI_ARADDR;
  assign r_idx = ra[7:4] - OFF_RGN0[7:4];
  assign r_rgn = ra[1:0] == 2'b00 &&
                 ra[7:4] >= OFF_RGN0[7:4] &&
                 r_idx < NR;

  always_comb begin
    rd_mux = '0;
    if (ra == OFF_CTRL) begin
      rd_mux = 32'(ctrl_q);
    end else if (ra == OFF_STATUS) begin
      rd_mux = 32'(viol_q);
    end else if (ra == OFF_VCOUNT) begin
      rd_mux = 32'(cnt_q);
    end else if (ra == OFF_VADDR) begin
      rd_mux = vaddr_q;
    end else if (r_rgn) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (r_idx == 4'(i)) begin
          case (ra[3:2])
            FLD_BASE:  rd_mux = base_q[i];
            FLD_LIMIT: rd_mux = limit_q[i];
            FLD_PERM:  rd_mux = 32'(perm_q[i]);
            default:   rd_mux = '0;
          endcase
        end
      end
    end
  end

  // ---- region lookup ----
  logic [NUM_REGIONS-1:0][ADDR_WIDTH-1:0] base_x, limit_x;
  logic [NUM_REGIONS-1:0][2:0]            perm_x;
  logic       m_hit, m_ok, allow_d;
  logic [3:0] m_region;

  // Table entries are 32-bit; wider check addresses see them zero-extended.
  always_comb begin
    for (int i = 0; i < NUM_REGIONS; i++) begin
      base_x[i]  = ADDR_WIDTH'(base_q[i]);
      limit_x[i] = ADDR_WIDTH'(limit_q[i]);
      perm_x[i]  = perm_q[i];
    end
  end

  region_match #(
    .NUM_REGIONS (NUM_REGIONS),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_match (
    .addr    (chk_addr),
    .write   (chk_write),
    .base    (base_x),
    .limit   (limit_x),
    .perm    (perm_x),
    .hit     (m_hit),
    .region  (m_region),
    .perm_ok (m_ok)
  );

  assign allow_d = !ctrl_q[CTRL_EN] ||
                   (m_hit ? m_ok : ctrl_q[CTRL_DEF]);

  // ---- check pipeline ----
  logic        chk_go, viol_evt, stat_clr;
  logic [31:0] res_addr_q;

  assign chk_ready = !ARESET && (!res_valid || res_ready);
  assign chk_go    = chk_valid && chk_ready;
  assign viol_evt  = res_valid && res_ready && !res_allow;
  assign stat_clr  = wr_go && w_stat &&
                     S_AXI_WSTRB[0] && S_AXI_WDATA[0];

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      res_valid  <= 1'b0;
      res_allow  <= 1'b0;
      res_region <= NO_MATCH;
      res_addr_q <= '0;
    end else if (chk_go) begin
      res_valid  <= 1'b1;
      res_allow  <= allow_d;
      res_region <= m_region;
      res_addr_q <= chk_addr[31:0];
    end else if (res_ready) begin
      res_valid  <= 1'b0;
    end
  end

  // ---- config and status registers ----
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= CFG_IDLE;
      ctrl_q  <= '0;
      viol_q  <= 1'b0;
      cnt_q   <= '0;
      vaddr_q <= '0;
      bresp_q <= RESP_OKAY;
      rdata_q <= '0;
      irq     <= 1'b0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
        base_q[i]  <= '0;
        limit_q[i] <= '0;
        perm_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      irq     <= viol_q && ctrl_q[CTRL_IRQ];
      if (wr_go) begin
        bresp_q <= w_ok ? RESP_OKAY : RESP_SLVERR;
        if (w_ctrl && S_AXI_WSTRB[0])
          ctrl_q <= S_AXI_WDATA[2:0];
        for (int i = 0; i < NUM_REGIONS; i++) begin
          if (w_rgn && w_idx == 4'(i)) begin
            case (wa[3:2])
              FLD_BASE: base_q[i] <= apply_strb(
                base_q[i], S_AXI_WDATA, S_AXI_WSTRB);
              FLD_LIMIT: limit_q[i] <= apply_strb(
                limit_q[i], S_AXI_WDATA, S_AXI_WSTRB);
              FLD_PERM: if (S_AXI_WSTRB[0])
                perm_q[i] <= S_AXI_WDATA[2:0];
              default: ;
            endcase
          end
        end
      end
      if (rd_go) rdata_q <= rd_mux;
      // A fresh violation outranks a same-cycle W1C.
      if (viol_evt) begin
        viol_q <= 1'b1;
        if (!viol_q) vaddr_q <= res_addr_q;
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_ONE;
      end else if (stat_clr) begin
        viol_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_region_guard.sv
// Directed self-checking bench for axi_region_guard.
// Four-bit violation counter so saturation is reachable.
module tb_axi_region_guard;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [7:0]  S_AXI_AWADDR;
  logic        S_AXI_AWVALID, S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID, S_AXI_BREADY;
  logic [7:0]  S_AXI_ARADDR;
  logic        S_AXI_ARVALID, S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID, S_AXI_RREADY;
  logic        chk_valid, chk_ready, chk_write;
  logic [31:0] chk_addr;
  logic        res_valid, res_ready, res_allow;
  logic [3:0]  res_region;
  logic        irq;

  int vectors    = 0;
  int miscompares = 0;

  always #5 ACLK = ~ACLK;

  axi_region_guard #(
    .ADDR_WIDTH  (32),
    .NUM_REGIONS (4),
    .CNT_WIDTH   (4)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .chk_valid     (chk_valid),
    .chk_ready     (chk_ready),
    .chk_addr      (chk_addr),
    .chk_write     (chk_write),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_allow     (res_allow),
    .res_region    (res_region),
    .irq           (irq)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    int n;
    @(negedge ACLK);
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    #1;
    n = 0;
    while (!S_AXI_AWREADY && n < 20) begin
      @(negedge ACLK); #1; n++;
    end
    if (n >= 20) begin
      miscompares++;
      $display("FAIL aw_timeout: addr %h got no AWREADY, want AWREADY=1", a);
    end
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
    n = 0;
    while (!S_AXI_BVALID && n < 20) begin
      @(negedge ACLK); n++;
    end
    if (n >= 20) begin
      miscompares++;
      $display("FAIL b_timeout: addr %h got no BVALID, want BVALID=1", a);
    end
    resp = S_AXI_BRESP;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d,
                          output logic [1:0] resp);
    int n;
    @(negedge ACLK);
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    #1;
    n = 0;
    while (!S_AXI_ARREADY && n < 20) begin
      @(negedge ACLK); #1; n++;
    end
    if (n >= 20) begin
      miscompares++;
      $display("FAIL ar_timeout: addr %h got no ARREADY, want ARREADY=1", a);
    end
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1;
    n = 0;
    while (!S_AXI_RVALID && n < 20) begin
      @(negedge ACLK); n++;
    end
    if (n >= 20) begin
      miscompares++;
      $display("FAIL r_timeout: addr %h got no RVALID, want RVALID=1", a);
    end
    d = S_AXI_RDATA; resp = S_AXI_RRESP;
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic do_check(input logic [31:0] a, input logic w,
                          output logic allow, output logic [3:0] rg);
    int n;
    @(negedge ACLK);
    chk_addr = a; chk_write = w; chk_valid = 1'b1; res_ready = 1'b0;
    #1;
    n = 0;
    while (!chk_ready && n < 20) begin
      @(negedge ACLK); #1; n++;
    end
    @(posedge ACLK); #1;
    chk_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 20) begin
      @(negedge ACLK); n++;
    end
    if (n >= 20) begin
      miscompares++;
      $display("FAIL res_timeout: addr %h got no res_valid, want 1", a);
    end
    allow = res_allow; rg = res_region;
    res_ready = 1'b1;
    @(posedge ACLK); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic [1:0]  r;
    logic [7:0]  outs;
    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0;
    S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    chk_valid = 1'b0; chk_addr = '0; chk_write = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge ACLK);
    outs = {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY,
            S_AXI_RVALID, chk_ready, res_valid, irq};
    vectors++;
    if (outs !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_outs: got %b want 00000000", outs);
    end
    ARESET = 1'b0;
    #1;
    vectors++;
    if (chk_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_chk_ready: got %b want 1", chk_ready);
    end
    axi_read(8'h00, d, r);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %h want 00000000", d);
    end
    axi_read(8'h08, d, r);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_vcount: got %h want 00000000", d);
    end
  endtask

  task automatic test_config;
    logic [31:0] d;
    logic [1:0]  r, racc;
    racc = 2'b00;
    axi_write(8'h10, 32'h0000_1000, 4'hF, r); racc |= r;
    axi_write(8'h14, 32'h0000_1FFF, 4'hF, r); racc |= r;
    axi_write(8'h18, 32'h0000_0005, 4'hF, r); racc |= r;
    axi_write(8'h00, 32'h0000_0005, 4'hF, r); racc |= r;
    vectors++;
    if (racc !== 2'b00) begin
      miscompares++;
      $display("FAIL cfg_bresp: got %b want 00", racc);
    end
    axi_read(8'h10, d, r);
    vectors++;
    if (d !== 32'h1000 || r !== 2'b00) begin
      miscompares++;
      $display("FAIL cfg_base0: got %h/%b want 00001000/00", d, r);
    end
    axi_read(8'h14, d, r);
    vectors++;
    if (d !== 32'h1FFF) begin
      miscompares++;
      $display("FAIL cfg_limit0: got %h want 00001fff", d);
    end
    axi_read(8'h18, d, r);
    vectors++;
    if (d !== 32'h5) begin
      miscompares++;
      $display("FAIL cfg_perm0: got %h want 00000005", d);
    end
    axi_read(8'h00, d, r);
    vectors++;
    if (d !== 32'h5) begin
      miscompares++;
      $display("FAIL cfg_ctrl: got %h want 00000005", d);
    end
    axi_write(8'h08, 32'hDEAD_BEEF, 4'hF, r);
    vectors++;
    if (r !== 2'b10) begin
      miscompares++;
      $display("FAIL cfg_ro_bresp: got %b want 10", r);
    end
    axi_write(8'h1C, 32'h1234_5678, 4'hF, r);
    vectors++;
    if (r !== 2'b10) begin
      miscompares++;
      $display("FAIL cfg_unmapped_bresp: got %b want 10", r);
    end
    axi_read(8'h1C, d, r);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL cfg_unmapped_rd: got %h want 00000000", d);
    end
    axi_write(8'h20, 32'hFFFF_FFFF, 4'b0011, r);
    axi_read(8'h20, d, r);
    vectors++;
    if (d !== 32'h0000_FFFF) begin
      miscompares++;
      $display("FAIL cfg_wstrb: got %h want 0000ffff", d);
    end
  endtask

  task automatic test_check;
    logic        al;
    logic [3:0]  rg;
    logic [31:0] d;
    logic [1:0]  r;
    do_check(32'h1800, 1'b0, al, rg);
    vectors++;
    if (al !== 1'b1 || rg !== 4'd0) begin
      miscompares++;
      $display("FAIL chk_read: got allow %b region %0d want 1/0", al, rg);
    end
    do_check(32'h1800, 1'b1, al, rg);
    vectors++;
    if (al !== 1'b0 || rg !== 4'd0) begin
      miscompares++;
      $display("FAIL chk_write: got allow %b region %0d want 0/0", al, rg);
    end
    @(posedge ACLK); #1;
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++;
      $display("FAIL chk_irq: got %b want 1", irq);
    end
    axi_read(8'h08, d, r);
    vectors++;
    if (d !== 32'd1) begin
      miscompares++;
      $display("FAIL chk_vcount: got %h want 00000001", d);
    end
    axi_read(8'h0C, d, r);
    vectors++;
    if (d !== 32'h1800) begin
      miscompares++;
      $display("FAIL chk_vaddr: got %h want 00001800", d);
    end
  endtask

  task automatic test_overlap;
    logic        al;
    logic [3:0]  rg;
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(8'h20, 32'h1000, 4'hF, r);
    axi_write(8'h24, 32'h10FF, 4'hF, r);
    axi_write(8'h28, 32'h7, 4'hF, r);
    do_check(32'h1010, 1'b0, al, rg);
    vectors++;
    if (al !== 1'b1 || rg !== 4'd0) begin
      miscompares++;
      $display("FAIL ovl_prio: got allow %b region %0d want 1/0", al, rg);
    end
    do_check(32'h3000, 1'b0, al, rg);
    vectors++;
    if (al !== 1'b0 || rg !== 4'hF) begin
      miscompares++;
      $display("FAIL ovl_nomatch: got allow %b region %0d want 0/15", al, rg);
    end
    axi_write(8'h30, 32'h5000, 4'hF, r);
    axi_write(8'h34, 32'h4000, 4'hF, r);
    axi_write(8'h38, 32'h7, 4'hF, r);
    do_check(32'h4800, 1'b0, al, rg);
    vectors++;
    if (al !== 1'b0 || rg !== 4'hF) begin
      miscompares++;
      $display("FAIL ovl_inverted: got allow %b region %0d want 0/15", al, rg);
    end
    do_check(32'h1FFF, 1'b0, al, rg);
    vectors++;
    if (al !== 1'b1 || rg !== 4'd0) begin
      miscompares++;
      $display("FAIL ovl_limit_edge: got allow %b region %0d want 1/0", al, rg);
    end
    do_check(32'h1000, 1'b1, al, rg);
    vectors++;
    if (al !== 1'b0 || rg !== 4'd0) begin
      miscompares++;
      $display("FAIL ovl_base_edge: got allow %b region %0d want 0/0", al, rg);
    end
    axi_write(8'h00, 32'h4, 4'hF, r);
    do_check(32'h3000, 1'b0, al, rg);
    vectors++;
    if (al !== 1'b1 || rg !== 4'hF) begin
      miscompares++;
      $display("FAIL ovl_disabled: got allow %b region %0d want 1/15", al, rg);
    end
    axi_write(8'h00, 32'h5, 4'hF, r);
    axi_read(8'h08, d, r);
    vectors++;
    if (d !== 32'd4) begin
      miscompares++;
      $display("FAIL ovl_vcount: got %h want 00000004", d);
    end
    axi_read(8'h0C, d, r);
    vectors++;
    if (d !== 32'h1800) begin
      miscompares++;
      $display("FAIL ovl_vaddr_kept: got %h want 00001800", d);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] d;
    logic [1:0]  r;
    int          bad;
    @(negedge ACLK);
    chk_addr = 32'h1800; chk_write = 1'b1; chk_valid = 1'b1;
    res_ready = 1'b0;
    @(posedge ACLK);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      if (chk_ready !== 1'b0 || res_valid !== 1'b1 ||
          res_allow !== 1'b0 || res_region !== 4'd0) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL bp_stall: got %0d unstable cycles want 0", bad);
    end
    chk_valid = 1'b0; res_ready = 1'b1;
    @(posedge ACLK); #1;
    res_ready = 1'b0;
    axi_read(8'h08, d, r);
    vectors++;
    if (d !== 32'd5) begin
      miscompares++;
      $display("FAIL bp_vcount: got %h want 00000005", d);
    end
  endtask

  task automatic test_saturation;
    logic        al;
    logic [3:0]  rg;
    logic [31:0] d;
    logic [1:0]  r;
    int          n;
    for (int i = 0; i < 20; i++) do_check(32'h3000, 1'b0, al, rg);
    axi_read(8'h08, d, r);
    vectors++;
    if (d !== 32'hF) begin
      miscompares++;
      $display("FAIL sat_vcount: got %h want 0000000f", d);
    end
    @(negedge ACLK);
    chk_addr = 32'h3000; chk_write = 1'b0; chk_valid = 1'b1;
    res_ready = 1'b0;
    @(posedge ACLK); #1;
    chk_valid = 1'b0;
    @(negedge ACLK);
    S_AXI_AWADDR = 8'h04; S_AXI_WDATA = 32'h1; S_AXI_WSTRB = 4'h1;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; res_ready = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; res_ready = 1'b0;
    S_AXI_BREADY = 1'b1;
    n = 0;
    while (!S_AXI_BVALID && n < 20) begin
      @(negedge ACLK); n++;
    end
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
    axi_read(8'h04, d, r);
    vectors++;
    if (d !== 32'h1) begin
      miscompares++;
      $display("FAIL sat_w1c_race: got %h want 00000001", d);
    end
    axi_write(8'h04, 32'h1, 4'h1, r);
    axi_read(8'h04, d, r);
    vectors++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_w1c: got status %h irq %b want 0/0", d, irq);
    end
    do_check(32'h3004, 1'b0, al, rg);
    axi_read(8'h0C, d, r);
    vectors++;
    if (d !== 32'h3004) begin
      miscompares++;
      $display("FAIL sat_vaddr_new: got %h want 00003004", d);
    end
  endtask

  task automatic test_reset_mid;
    logic        al;
    logic [3:0]  rg;
    logic [31:0] d;
    logic [1:0]  r;
    logic [6:0]  outs;
    @(negedge ACLK);
    chk_addr = 32'h1800; chk_write = 1'b0; chk_valid = 1'b1;
    res_ready = 1'b0; S_AXI_RREADY = 1'b0;
    S_AXI_ARADDR = 8'h10; S_AXI_ARVALID = 1'b1;
    @(posedge ACLK); #1;
    chk_valid = 1'b0; S_AXI_ARVALID = 1'b0;
    vectors++;
    if (S_AXI_RVALID !== 1'b1 || res_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_setup: got rvalid %b res_valid %b want 1/1",
               S_AXI_RVALID, res_valid);
    end
    @(negedge ACLK);
    ARESET = 1'b1;
    #1;
    outs = {S_AXI_AWREADY, S_AXI_BVALID, S_AXI_ARREADY,
            S_AXI_RVALID, chk_ready, res_valid, irq};
    vectors++;
    if (outs !== 7'h00) begin
      miscompares++;
      $display("FAIL rst_mid_outs: got %b want 0000000", outs);
    end
    @(negedge ACLK);
    ARESET = 1'b0;
    S_AXI_RREADY = 1'b1; res_ready = 1'b1;
    repeat (3) @(negedge ACLK);
    vectors++;
    if (S_AXI_RVALID !== 1'b0 || res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_no_resp: got rvalid %b res_valid %b want 0/0",
               S_AXI_RVALID, res_valid);
    end
    S_AXI_RREADY = 1'b0; res_ready = 1'b0;
    axi_read(8'h10, d, r);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_base0: got %h want 00000000", d);
    end
    axi_read(8'h04, d, r);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_status: got %h want 00000000", d);
    end
    do_check(32'h1800, 1'b1, al, rg);
    vectors++;
    if (al !== 1'b1 || rg !== 4'hF) begin
      miscompares++;
      $display("FAIL rst_next_chk: got allow %b region %0d want 1/15", al, rg);
    end
    axi_write(8'h00, 32'h2, 4'hF, r);
    axi_read(8'h00, d, r);
    vectors++;
    if (d !== 32'h2) begin
      miscompares++;
      $display("FAIL rst_next_cfg: got %h want 00000002", d);
    end
  endtask

  initial begin
    test_reset;
    test_config;
    test_check;
    test_overlap;
    test_backpressure;
    test_saturation;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_region_guard.md
AXI_REGION_GUARD -- requirements
Module: axi_region_guard

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, checked address width (32..64).
REQ-002 SHALL have parameter NUM_REGIONS, default 4, region count (1..15).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, violation counter width.
REQ-004 SHALL have port ACLK  in  1  sole clock, rising edge.
REQ-005 SHALL have port ARESET  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports S_AXI_AWADDR/AWVALID/AWREADY, S_AXI_WDATA(32)/WSTRB(4)/WVALID/WREADY, S_AXI_BRESP(2)/BVALID/BREADY, S_AXI_ARADDR/ARVALID/ARREADY, S_AXI_RDATA(32)/RRESP(2)/RVALID/RREADY; these form the AXI4-Lite config slave, with 8-bit addresses.
REQ-007 SHALL have ports chk_valid in 1, chk_ready out 1, chk_addr in ADDR_WIDTH, chk_write in 1; these form the check request.
REQ-008 SHALL have ports res_valid out 1, res_ready in 1, res_allow out 1, res_region out 4 (15 = no match); these form the check result.
REQ-009 SHALL have port irq  out  1  level interrupt.

Function
REQ-010 SHALL use this register map: 0x00 CTRL (b0 enable, b1 default_allow, b2 irq_en); 0x04 STATUS (b0 viol, W1C); 0x08 VIOL_COUNT (RO); 0x0C VIOL_ADDR (RO, low 32 bits).
REQ-011 SHALL place region i registers at 0x10+16*i: BASE, LIMIT, PERM (b0 R, b1 W, b2 valid); offset +0xC and unmapped addresses read 0.
REQ-012 SHALL implement the config FSM with states IDLE, WRESP, RDATA; IDLE->WRESP when AWVALID&WVALID; otherwise IDLE->RDATA when ARVALID; write wins a simultaneous arrival.
REQ-013 SHALL raise AWREADY/WREADY together for one cycle on acceptance; BVALID/RVALID SHALL hold until BREADY/RREADY, then return to IDLE.
REQ-014 SHALL apply WSTRB per byte; writes to RO or unmapped addresses SHALL be ignored with BRESP=2'b10; all other responses SHALL be 2'b00.
REQ-015 SHALL drive chk_ready = !res_valid | res_ready (single-entry pipeline, back-to-back throughput).
REQ-016 SHALL present the result one cycle after acceptance, computed from table/CTRL values at the accept cycle.
REQ-017 SHALL treat region i as matching when valid & BASE<=chk_addr<=LIMIT (unsigned, inclusive); lowest index wins.
REQ-018 SHALL set res_allow = matched PERM.W (write) or PERM.R (read); with no match, res_allow = default_allow.
REQ-019 SHALL force res_allow=1 when enable=0, with no violation recorded.
REQ-020 SHALL, on a denied result accepted (res_valid&res_ready), increment VIOL_COUNT saturating at all-ones and set STATUS.viol; VIOL_ADDR SHALL capture the address only if viol was 0.
REQ-021 SHALL let a new violation win when a STATUS W1C and that violation occur in the same cycle (viol stays 1).
REQ-022 SHALL drive irq = STATUS.viol & irq_en, registered.
REQ-023 SHALL treat BASE>LIMIT as a region that never matches.

Reset
REQ-024 SHALL on ARESET clear all registers: CTRL=0, STATUS=0, counter=0, VIOL_ADDR=0, all regions invalid, FSM=IDLE.
REQ-025 SHALL during reset drive all valid/ready outputs to 0 and irq to 0; chk_ready SHALL be 1 from the first cycle after deassertion.
REQ-026 SHALL drop any in-flight result or config response on reset mid-operation, with no response issued afterward.

Structure
REQ-027 SHALL put register offsets, CTRL/PERM bit positions, the RESP codes and the NO_MATCH constant (4'hF) in package region_guard_pkg.
REQ-028 SHALL implement the address comparison/priority encoder as sub-module region_match (combinational, parametrised by NUM_REGIONS/ADDR_WIDTH).

Verification
REQ-029 SHALL cover config: write BASE0=0x1000, LIMIT0=0x1FFF, PERM0=0x5, CTRL=0x5 -> read back identical values, BRESP=0.
REQ-030 SHALL cover check: read at 0x1800 -> allow=1, region=0; write at 0x1800 -> allow=0, VIOL_COUNT=1, VIOL_ADDR=0x1800, irq=1 one cycle later.
REQ-031 SHALL cover overlap: region1 0x1000-0x10FF RW, region0 as above; read at 0x1010 -> region=0; address 0x3000 with default_allow=0 -> allow=0, region=15.
REQ-032 SHALL cover backpressure: res_ready low 5 cycles with chk_valid held -> chk_ready=0, result stable, no extra count.
REQ-033 SHALL cover saturation: CNT_WIDTH=4 with 20 denials -> VIOL_COUNT=0xF; W1C coincident with a denial -> viol stays 1.
REQ-034 SHALL cover reset: ARESET mid-RDATA and mid-result -> all valids 0, registers reset, next transaction normal.
